control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPW, default 5, opcode field width.
REQ-002 Parameter ALUW, default 5, ALU select width.
REQ-003 Parameter MAX_WAIT, default 8, maximum memory wait cycles before fault (1..255).
REQ-004 Parameter CNTW, default 16, retired-instruction counter width.
REQ-005 clock  input  1  sole clock; all state changes on rising edge.
REQ-006 clear  input  1  synchronous active-high reset, sampled on rising edge of clock.
REQ-007 ir_opcode  input  OPW  opcode field of datapath IR; valid from T3 onward.
REQ-008 con_ff  input  1  branch-condition flip-flop from datapath.
REQ-009 mem_ready  input  1  RAM completion handshake; 1 = current read/write done this cycle.
REQ-010 stop  input  1  halt request, honoured only at instruction boundary.
REQ-011 ctrl_bus  output  21  datapath strobes: 0 PCout, 1 IncPC, 2 PCin, 3 MARin, 4 MDRin, 5 MDRout, 6 IRin, 7 read, 8 write, 9 RAMenable, 10 Gra, 11 Grb, 12 Grc, 13 Rin, 14 Rout, 15 BAout, 16 Cout, 17 Yin, 18 ZLOin, 19 ZLOout, 20 conin.
REQ-012 alu_control  output  ALUW  ALU operation select.
REQ-013 state  output  4  encoding: RESET 0, T0 1, T1 2, T2 3, T3 4, T4 5, T5 6, T6 7, T7 8, HALT 9, FAULT 10.
REQ-014 run  output  1  1 in every state except RESET, HALT, FAULT.
REQ-015 fault  output  1  1 only in FAULT.
REQ-016 instr_count  output  CNTW  retired instructions, wraps modulo 2^CNTW.

Function
REQ-017 Outputs SHALL be Moore, decoded from state register and ir_opcode; unlisted strobes 0, alu_control 0 unless stated.
REQ-018 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, brx 10010, jr 10011, nop 11010, halt 11011; zero-extended/truncated to OPW.
REQ-019 RESET -> T0 unconditionally.
REQ-020 T0: PCout, MARin, IncPC; -> HALT if stop=1, else T1.
REQ-021 T1: read, RAMenable, MDRin; stays until mem_ready=1, then -> T2.
REQ-022 T2: MDRout, IRin; -> T3.
REQ-023 T3: ld/ldi/st/addi: Grb, BAout, Yin. ALU ops: Grb, Rout, Yin. brx: Gra, Rout, conin. jr: Gra, Rout, PCin, retire -> T0. nop: retire -> T0. halt: retire -> HALT. Other opcodes -> FAULT.
REQ-024 T4: ld/ldi/st/addi: Cout, ZLOin, alu_control=00011. ALU ops: Grc, Rout, ZLOin, alu_control=ir_opcode. brx: PCout, Yin.
REQ-025 T5: ldi/addi/ALU ops: ZLOout, Gra, Rin, retire -> T0. ld/st: ZLOout, MARin. brx: Cout, ZLOin, alu_control=00011.
REQ-026 T6: ld: read, RAMenable, MDRin, stays until mem_ready=1. st: Gra, Rout, MDRin. brx: ZLOout and PCin only if con_ff=1, retire -> T0.
REQ-027 T7: ld: MDRout, Gra, Rin, retire -> T0. st: write, RAMenable, stays until mem_ready=1, then retire -> T0.
REQ-028 Wait counter clears on entry to each wait state (T1, ld T6, st T7) and increments per cycle with mem_ready=0; reaching MAX_WAIT -> FAULT; mem_ready=1 on the MAX_WAIT-th cycle counts as success.
REQ-029 Retire SHALL increment instr_count on the exiting edge; wraps all-ones -> 0.
REQ-030 HALT and FAULT SHALL be absorbing; only clear exits; ctrl_bus=0 in both.
REQ-031 stop asserted outside T0 SHALL be ignored until the next T0.

Reset
REQ-032 clear=1 on any edge, any state, including mid-wait: state=RESET, ctrl_bus=0, alu_control=0, run=0, fault=0, instr_count=0, wait counter=0; clear dominates all other inputs.

Verification
REQ-033 clear one cycle, mem_ready=1 always, ir_opcode=ldi -> states 0,1,2,3,4,5,6,1; T4 alu_control=00011, Cout=1; T5 Gra=Rin=1; instr_count=1.
REQ-034 ld with mem_ready low 3 cycles in T1 and T6 -> T1 held 4 cycles, T6 held 4 cycles, T7 Gra=Rin=MDRout=1, instr_count=1.
REQ-035 brx with con_ff=0 then 1 -> PCin=0 in first T6, PCin=1 in second; both retire.
REQ-036 mem_ready=0 forever, MAX_WAIT=8 -> FAULT on 9th cycle after T0, fault=1, run=0; clear -> RESET.
REQ-037 ir_opcode=11111 -> FAULT after T3; halt opcode -> HALT, instr_count incremented, stop pulsed in T2 ignored.
REQ-038 CNTW=2, four nops -> instr_count 1,2,3,0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for a single-bus datapath: one state per cycle, Moore strobes.
// Stalls in T1, ld-T6 and st-T7 until mem_ready; a stall reaching MAX_WAIT cycles drops into FAULT.
module control_sequencer #(
   parameter int OPW      = 5,
   parameter int ALUW     = 5,
   parameter int MAX_WAIT = 8,
   parameter int CNTW     = 16
) (
   input  logic            clock,
   input  logic            clear,
   input  logic [OPW-1:0]  ir_opcode,
   input  logic            con_ff,
   input  logic            mem_ready,
   input  logic            stop,
   output logic [20:0]     ctrl_bus,
   output logic [ALUW-1:0] alu_control,
   output logic [3:0]      state,
   output logic            run,
   output logic            fault,
   output logic [CNTW-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_T7    = 4'd8,
      S_HALT  = 4'd9,
      S_FAULT = 4'd10
   } state_t;

   localparam int B_PCOUT  = 0;
   localparam int B_INCPC  = 1;
   localparam int B_PCIN   = 2;
   localparam int B_MARIN  = 3;
   localparam int B_MDRIN  = 4;
   localparam int B_MDROUT = 5;
   localparam int B_IRIN   = 6;
   localparam int B_READ   = 7;
   localparam int B_WRITE  = 8;
   localparam int B_RAMEN  = 9;
   localparam int B_GRA    = 10;
   localparam int B_GRB    = 11;
   localparam int B_GRC    = 12;
   localparam int B_RIN    = 13;
   localparam int B_ROUT   = 14;
   localparam int B_BAOUT  = 15;
   localparam int B_COUT   = 16;
   localparam int B_YIN    = 17;
   localparam int B_ZLOIN  = 18;
   localparam int B_ZLOOUT = 19;
   localparam int B_CONIN  = 20;

   localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
   localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
   localparam logic [OPW-1:0] OP_BRX  = OPW'(5'b10010);
   localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
   localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
   localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

   localparam logic [ALUW-1:0] ALU_ADD   = ALUW'(5'b00011);
   localparam logic [7:0]      WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t          state_q, state_d;
   logic [7:0]      wait_q, wait_d;
   logic [CNTW-1:0] instr_count_q, instr_count_d;
   logic            retire;
   logic [20:0]     strobe;

   logic is_ld, is_ldi, is_st, is_addi, is_alu, is_brx, is_jr, is_nop, is_halt;
   logic is_imm;

   always_comb begin
      is_ld   = (ir_opcode == OP_LD);
      is_ldi  = (ir_opcode == OP_LDI);
      is_st   = (ir_opcode == OP_ST);
      is_addi = (ir_opcode == OP_ADDI);
      is_alu  = (ir_opcode == OP_ADD) || (ir_opcode == OP_SUB) ||
                (ir_opcode == OP_AND) || (ir_opcode == OP_OR);
      is_brx  = (ir_opcode == OP_BRX);
      is_jr   = (ir_opcode == OP_JR);
      is_nop  = (ir_opcode == OP_NOP);
      is_halt = (ir_opcode == OP_HALT);
      // ld/ldi/st/addi all form base+offset (or immediate) through BAout in T3/T4
      is_imm  = is_ld || is_ldi || is_st || is_addi;
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q       <= S_RESET;
         wait_q        <= '0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         instr_count_q <= instr_count_d;
      end
   end

   // wait_d defaults to zero so the counter restarts on every entry to a wait state
   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      retire  = 1'b0;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0:    state_d = stop ? S_HALT : S_T1;
         S_T1: begin
            if (mem_ready)                state_d = S_T2;
            else if (wait_q == WAIT_LAST) state_d = S_FAULT;
            else                          wait_d  = wait_q + 8'd1;
         end
         S_T2: state_d = S_T3;
         S_T3: begin
            if (is_imm || is_alu || is_brx) begin
               state_d = S_T4;
            end else if (is_jr || is_nop) begin
               retire  = 1'b1;
               state_d = S_T0;
            end else if (is_halt) begin
               retire  = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_FAULT;
            end
         end
         S_T4: state_d = S_T5;
         S_T5: begin
            if (is_ldi || is_addi || is_alu) begin
               retire  = 1'b1;
               state_d = S_T0;
            end else if (is_ld || is_st || is_brx) begin
               state_d = S_T6;
            end else begin
               state_d = S_FAULT;
            end
         end
         S_T6: begin
            if (is_ld) begin
               if (mem_ready)                state_d = S_T7;
               else if (wait_q == WAIT_LAST) state_d = S_FAULT;
               else                          wait_d  = wait_q + 8'd1;
            end else if (is_st) begin
               state_d = S_T7;
            end else if (is_brx) begin
               retire  = 1'b1;
               state_d = S_T0;
            end else begin
               state_d = S_FAULT;
            end
         end
         S_T7: begin
            if (is_ld) begin
               retire  = 1'b1;
               state_d = S_T0;
            end else if (is_st) begin
               if (mem_ready) begin
                  retire  = 1'b1;
                  state_d = S_T0;
               end else if (wait_q == WAIT_LAST) begin
                  state_d = S_FAULT;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end else begin
               state_d = S_FAULT;
            end
         end
         S_HALT:  state_d = S_HALT;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
      instr_count_d = instr_count_q + CNTW'(retire);
   end

   always_comb begin
      strobe      = '0;
      alu_control = '0;
      case (state_q)
         S_T0: begin
            strobe[B_PCOUT] = 1'b1;
            strobe[B_MARIN] = 1'b1;
            strobe[B_INCPC] = 1'b1;
         end
         S_T1: begin
            strobe[B_READ]  = 1'b1;
            strobe[B_RAMEN] = 1'b1;
            strobe[B_MDRIN] = 1'b1;
         end
         S_T2: begin
            strobe[B_MDROUT] = 1'b1;
            strobe[B_IRIN]   = 1'b1;
         end
         S_T3: begin
            if (is_imm) begin
               strobe[B_GRB]   = 1'b1;
               strobe[B_BAOUT] = 1'b1;
               strobe[B_YIN]   = 1'b1;
            end else if (is_alu) begin
               strobe[B_GRB]  = 1'b1;
               strobe[B_ROUT] = 1'b1;
               strobe[B_YIN]  = 1'b1;
            end else if (is_brx) begin
               strobe[B_GRA]   = 1'b1;
               strobe[B_ROUT]  = 1'b1;
               strobe[B_CONIN] = 1'b1;
            end else if (is_jr) begin
               strobe[B_GRA]  = 1'b1;
               strobe[B_ROUT] = 1'b1;
               strobe[B_PCIN] = 1'b1;
            end
         end
         S_T4: begin
            if (is_imm) begin
               strobe[B_COUT]  = 1'b1;
               strobe[B_ZLOIN] = 1'b1;
               alu_control     = ALU_ADD;
            end else if (is_alu) begin
               strobe[B_GRC]   = 1'b1;
               strobe[B_ROUT]  = 1'b1;
               strobe[B_ZLOIN] = 1'b1;
               alu_control     = ALUW'(ir_opcode);
            end else if (is_brx) begin
               strobe[B_PCOUT] = 1'b1;
               strobe[B_YIN]   = 1'b1;
            end
         end
         S_T5: begin
            if (is_ldi || is_addi || is_alu) begin
               strobe[B_ZLOOUT] = 1'b1;
               strobe[B_GRA]    = 1'b1;
               strobe[B_RIN]    = 1'b1;
            end else if (is_ld || is_st) begin
               strobe[B_ZLOOUT] = 1'b1;
               strobe[B_MARIN]  = 1'b1;
            end else if (is_brx) begin
               strobe[B_COUT]  = 1'b1;
               strobe[B_ZLOIN] = 1'b1;
               alu_control     = ALU_ADD;
            end
         end
         S_T6: begin
            if (is_ld) begin
               strobe[B_READ]  = 1'b1;
               strobe[B_RAMEN] = 1'b1;
               strobe[B_MDRIN] = 1'b1;
            end else if (is_st) begin
               strobe[B_GRA]   = 1'b1;
               strobe[B_ROUT]  = 1'b1;
               strobe[B_MDRIN] = 1'b1;
            end else if (is_brx && con_ff) begin
               strobe[B_ZLOOUT] = 1'b1;
               strobe[B_PCIN]   = 1'b1;
            end
         end
         S_T7: begin
            if (is_ld) begin
               strobe[B_MDROUT] = 1'b1;
               strobe[B_GRA]    = 1'b1;
               strobe[B_RIN]    = 1'b1;
            end else if (is_st) begin
               strobe[B_WRITE] = 1'b1;
               strobe[B_RAMEN] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign ctrl_bus    = strobe;
   assign state       = state_q;
   assign run         = (state_q >= S_T0) && (state_q <= S_T7);
   assign fault       = (state_q == S_FAULT);
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a table-driven microprogram model.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clear, con_ff, mem_ready, stop;
   logic [4:0]  ir_opcode;
   logic [20:0] ctrl_bus, ctrl_bus2;
   logic [4:0]  alu_control, alu_control2;
   logic [3:0]  state, state2;
   logic        run, fault, run2, fault2;
   logic [15:0] instr_count;
   logic [1:0]  instr_count2;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clock(clk), .clear(clear), .ir_opcode(ir_opcode), .con_ff(con_ff),
      .mem_ready(mem_ready), .stop(stop), .ctrl_bus(ctrl_bus), .alu_control(alu_control),
      .state(state), .run(run), .fault(fault), .instr_count(instr_count));

   control_sequencer #(.CNTW(2)) dut2 (
      .clock(clk), .clear(clear), .ir_opcode(ir_opcode), .con_ff(con_ff),
      .mem_ready(mem_ready), .stop(stop), .ctrl_bus(ctrl_bus2), .alu_control(alu_control2),
      .state(state2), .run(run2), .fault(fault2), .instr_count(instr_count2));

   localparam int MAXW = 8;
   localparam int PCOUT=0, INCPC=1, PCIN=2, MARIN=3, MDRIN=4, MDROUT=5, IRIN=6, READ=7,
                  WRITE=8, RAMEN=9, GRA=10, GRB=11, GRC=12, RIN=13, ROUT=14, BAOUT=15,
                  COUT=16, YIN=17, ZLOIN=18, ZLOOUT=19, CONIN=20;

   // classes: 0 ld,1 ldi,2 st,3 addi,4 alu,5 brx,6 jr,7 nop,8 halt,9 illegal
   logic [20:0] tab [10][8];
   int          last_t [10];
   logic [4:0]  legal_ops [12];

   int ms, wc, cnt;
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [20:0] m(input int i);
      logic [20:0] one = 21'd1;
      return one << i;
   endfunction

   function automatic int cls_of(input logic [4:0] op);
      case (op)
         5'd0: return 0;   5'd1: return 1;   5'd2: return 2;   5'd12: return 3;
         5'd3, 5'd4, 5'd5, 5'd6: return 4;
         5'd18: return 5;  5'd19: return 6;  5'd26: return 7;  5'd27: return 8;
         default: return 9;
      endcase
   endfunction

   task automatic init_tab();
      logic [20:0] fetch_ba, add_off;
      for (int c = 0; c < 10; c++) for (int t = 0; t < 8; t++) tab[c][t] = '0;
      fetch_ba = m(GRB) | m(BAOUT) | m(YIN);
      add_off  = m(COUT) | m(ZLOIN);
      for (int c = 0; c < 4; c++) begin tab[c][3] = fetch_ba; tab[c][4] = add_off; end
      tab[0][5] = m(ZLOOUT) | m(MARIN);  tab[0][6] = m(READ) | m(RAMEN) | m(MDRIN);
      tab[0][7] = m(MDROUT) | m(GRA) | m(RIN);
      tab[1][5] = m(ZLOOUT) | m(GRA) | m(RIN);
      tab[2][5] = m(ZLOOUT) | m(MARIN);  tab[2][6] = m(GRA) | m(ROUT) | m(MDRIN);
      tab[2][7] = m(WRITE) | m(RAMEN);
      tab[3][5] = tab[1][5];
      tab[4][3] = m(GRB) | m(ROUT) | m(YIN);  tab[4][4] = m(GRC) | m(ROUT) | m(ZLOIN);
      tab[4][5] = tab[1][5];
      tab[5][3] = m(GRA) | m(ROUT) | m(CONIN); tab[5][4] = m(PCOUT) | m(YIN);
      tab[5][5] = add_off;
      tab[6][3] = m(GRA) | m(ROUT) | m(PCIN);
      last_t = '{7, 5, 7, 5, 5, 6, 3, 3, 3, 3};
      legal_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd19, 5'd26, 5'd27};
   endtask

   function automatic bit is_wait(input int c);
      return ms == 2 || (c == 0 && ms == 7) || (c == 2 && ms == 8);
   endfunction

   task automatic model_update();
      int  c;
      bit  adv, stay;
      c = cls_of(ir_opcode);
      adv = 0; stay = 0;
      if (clear) begin ms = 0; wc = 0; cnt = 0; return; end
      case (ms)
         0: ms = 1;
         1: ms = stop ? 9 : 2;
         9, 10: ;
         default: begin
            if (ms == 4 && c == 9) ms = 10;
            else if (is_wait(c)) begin
               if (mem_ready) adv = 1;
               else begin
                  wc++;
                  if (wc == MAXW) ms = 10; else stay = 1;
               end
            end else adv = 1;
         end
      endcase
      if (adv) begin
         if (ms >= 4 && ms - 1 == last_t[c]) begin
            cnt++;
            ms = (c == 8) ? 9 : 1;
         end else ms++;
      end
      if (!stay) wc = 0;
   endtask

   task automatic model_compare();
      logic [20:0] ec;
      logic [4:0]  ea;
      int          c, t;
      ec = '0; ea = '0;
      c = cls_of(ir_opcode);
      t = ms - 1;
      if (ms == 1)      ec = m(PCOUT) | m(MARIN) | m(INCPC);
      else if (ms == 2) ec = m(READ) | m(RAMEN) | m(MDRIN);
      else if (ms == 3) ec = m(MDROUT) | m(IRIN);
      else if (ms >= 4 && ms <= 8) begin
         ec = tab[c][t];
         if (c == 5 && t == 6 && con_ff) ec = m(ZLOOUT) | m(PCIN);
         if (t == 4 && c <= 3) ea = 5'b00011;
         if (t == 4 && c == 4) ea = ir_opcode;
         if (t == 5 && c == 5) ea = 5'b00011;
      end
      chk("state", 32'(state), 32'(ms));
      chk("ctrl_bus", 32'(ctrl_bus), 32'(ec));
      chk("alu_control", 32'(alu_control), 32'(ea));
      chk("run", 32'(run), 32'(ms >= 1 && ms <= 8));
      chk("fault", 32'(fault), 32'(ms == 10));
      chk("instr_count", 32'(instr_count), 32'(cnt % 65536));
      chk("instr_count_w2", 32'(instr_count2), 32'(cnt % 4));
   endtask

   // inputs are driven at the falling edge; outputs are compared 2ns after the rising edge
   task automatic cyc();
      @(posedge clk);
      model_update();
      #2;
      model_compare();
      @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1; stop = 1'b0;
      cyc();
      clear = 1'b0;
   endtask

   initial begin
      int n1, n6, pc0, pc1, nb, c0;
      init_tab();
      ms = 0; wc = 0; cnt = 0;
      clear = 1'b1; stop = 1'b0; con_ff = 1'b0; mem_ready = 1'b1; ir_opcode = 5'd1;
      @(negedge clk);

      // reset state, then ldi with ready memory
      do_clear();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ctrl", 32'(ctrl_bus), 32'd0);
      chk("rst_run", 32'(run), 32'd0);
      chk("rst_cnt", 32'(instr_count), 32'd0);
      for (int i = 0; i < 7; i++) begin
         cyc();
         if (state == 4'd5) begin
            chk("ldi_t4_alu", 32'(alu_control), 32'd3);
            chk("ldi_t4_cout", 32'(ctrl_bus[COUT]), 32'd1);
         end
         if (state == 4'd6) chk("ldi_t5_gra_rin", 32'({ctrl_bus[GRA], ctrl_bus[RIN]}), 32'd3);
      end
      chk("ldi_back_t0", 32'(state), 32'd1);
      chk("ldi_cnt", 32'(instr_count), 32'd1);

      // ld with three not-ready cycles in each wait state
      do_clear();
      ir_opcode = 5'd0; n1 = 0; n6 = 0;
      for (int i = 0; i < 40 && !(ms == 1 && cnt == 1); i++) begin
         mem_ready = ((ms == 2 || ms == 7) && wc < 3) ? 1'b0 : 1'b1;
         cyc();
         if (state == 4'd2) n1++;
         if (state == 4'd7) n6++;
         if (state == 4'd8) chk("ld_t7_strobes",
             32'({ctrl_bus[GRA], ctrl_bus[RIN], ctrl_bus[MDROUT]}), 32'd7);
      end
      chk("ld_t1_cycles", 32'(n1), 32'd4);
      chk("ld_t6_cycles", 32'(n6), 32'd4);
      chk("ld_cnt", 32'(instr_count), 32'd1);

      // brx taken/not taken
      do_clear();
      mem_ready = 1'b1; ir_opcode = 5'd18; pc0 = -1; pc1 = -1; nb = 0;
      for (int i = 0; i < 40 && nb < 2; i++) begin
         con_ff = (cnt == 0) ? 1'b0 : 1'b1;
         c0 = cnt;
         cyc();
         if (state == 4'd7) begin
            if (cnt == 0) pc0 = int'(ctrl_bus[PCIN]); else pc1 = int'(ctrl_bus[PCIN]);
         end
         if (cnt != c0) nb++;
      end
      chk("brx_pcin_nt", 32'(pc0), 32'd0);
      chk("brx_pcin_t", 32'(pc1), 32'd1);
      chk("brx_retired", 32'(instr_count), 32'd2);

      // memory never ready
      do_clear();
      mem_ready = 1'b0; ir_opcode = 5'd26;
      cyc();
      chk("timeout_t0", 32'(state), 32'd1);
      repeat (8) cyc();
      chk("timeout_still_t1", 32'(state), 32'd2);
      cyc();
      chk("timeout_fault", 32'({state, fault, run}), 32'({4'd10, 1'b1, 1'b0}));
      repeat (3) cyc();
      chk("fault_absorb", 32'(state), 32'd10);
      do_clear();
      chk("fault_clear", 32'(state), 32'd0);

      // illegal opcode, then halt with a stray stop in T2
      mem_ready = 1'b1; ir_opcode = 5'd31;
      repeat (5) cyc();
      chk("illegal_fault", 32'(state), 32'd10);
      do_clear();
      ir_opcode = 5'd27;
      for (int i = 0; i < 6; i++) begin
         stop = (ms == 3) ? 1'b1 : 1'b0;
         cyc();
      end
      stop = 1'b0;
      chk("halt_state", 32'(state), 32'd9);
      chk("halt_cnt", 32'(instr_count), 32'd1);
      chk("halt_ctrl", 32'(ctrl_bus), 32'd0);

      // narrow counter wraps
      do_clear();
      ir_opcode = 5'd26;
      cyc();
      for (int k = 1; k <= 4; k++) begin
         repeat (4) cyc();
         chk("wrap_cnt", 32'(instr_count2), 32'(k % 4));
      end

      // randomized episodes
      for (int e = 0; e < 250; e++) begin
         do_clear();
         for (int i = 0; i < 60; i++) begin
            if (ms <= 3) begin
               if ($urandom_range(0, 13) < 12) ir_opcode = legal_ops[$urandom_range(0, 11)];
               else ir_opcode = 5'($urandom_range(0, 31));
            end
            mem_ready = ($urandom_range(0, 9) < 7);
            stop      = ($urandom_range(0, 19) == 0);
            con_ff    = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 99) == 0);
            cyc();
            clear = 1'b0;
            if (ms >= 9 && $urandom_range(0, 3) == 0) break;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
